// File: rtl/seg_scanner.sv
// Eight-digit multiplexed seven-segment scanner with a per-frame shadow register
// so digit data never tears mid-scan; outputs are registered from scan state.
module seg_scanner #(
    parameter int         SCAN_DIV   = 100000,
    parameter int         DEAD       = 1000,
    parameter logic [3:0] BLANK_CODE = 4'hB
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] dataBus,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   shd;
    logic          tick;
    logic          dead;
    logic          wrap;
    logic [3:0]    nib;
    logic [6:0]    seg_dec;
    logic [7:0]    an_nxt;

    assign tick = (cnt == LAST);
    assign wrap = tick && (idx == 3'd7);

    // A zero-length dead window is elaborated away rather than compared against zero.
    generate
        if (DEAD == 0) begin : g_nodead
            always_comb dead = 1'b0;
        end else begin : g_dead
            localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
            always_comb dead = (cnt < DEAD_C);
        end
    endgenerate

    always_comb begin
        nib     = shd[{idx, 2'b00} +: 4];
        seg_dec = '1;
        case (nib)
            4'h0: seg_dec = 7'h40;
            4'h1: seg_dec = 7'h79;
            4'h2: seg_dec = 7'h24;
            4'h3: seg_dec = 7'h30;
            4'h4: seg_dec = 7'h19;
            4'h5: seg_dec = 7'h12;
            4'h6: seg_dec = 7'h02;
            4'h7: seg_dec = 7'h78;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h10;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h03;
            4'hC: seg_dec = 7'h46;
            4'hD: seg_dec = 7'h21;
            4'hE: seg_dec = 7'h06;
            4'hF: seg_dec = 7'h0E;
            default: seg_dec = '1;
        endcase
        if (nib == BLANK_CODE) seg_dec = '1;
        an_nxt = dead ? '1 : ~(8'b1 << idx);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt        <= '0;
            idx        <= '0;
            shd        <= {8{BLANK_CODE}};
            AN         <= '1;
            SEG        <= '1;
            DP         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + 1'b1;
            if (tick) idx <= idx + 3'd1;
            if (wrap) shd <= dataBus;
            frame_done <= wrap;
            AN         <= an_nxt;
            SEG        <= seg_dec;
            DP         <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scanner.sv
// Self-checking bench for seg_scanner (SCAN_DIV=4, DEAD=1) plus a DEAD=0 build
// sharing the same stimulus; expected outputs come from a time-indexed scan model.
module tb_seg_scanner;

    localparam int         SD    = 4;
    localparam int         DD    = 1;
    localparam logic [3:0] BLANK = 4'hB;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] dataBus = 32'h01234567;
    logic [7:0]  AN,  an0;
    logic [6:0]  SEG, seg0;
    logic        DP,  dp0;
    logic        frame_done, fd0;

    seg_scanner #(.SCAN_DIV(SD), .DEAD(DD), .BLANK_CODE(BLANK)) u_dut (
        .clk(clk), .clr(clr), .dataBus(dataBus),
        .AN(AN), .SEG(SEG), .DP(DP), .frame_done(frame_done)
    );

    seg_scanner #(.SCAN_DIV(SD), .DEAD(0), .BLANK_CODE(BLANK)) u_dut0 (
        .clk(clk), .clr(clr), .dataBus(dataBus),
        .AN(an0), .SEG(seg0), .DP(dp0), .frame_done(fd0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    typedef struct {
        int          n;
        logic [31:0] data;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        fd;
    } vec_t;

    logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    exp_t        sb[$];
    logic [31:0] m_shd = {8{BLANK}};
    int          n = 0;          // edges since reset release
    int          n_cmp = 0;
    int          n_bad = 0;
    int          pulses = 0;
    vec_t        tbl[16];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n);
        end
    endfunction

    task automatic step();
        exp_t       e;
        logic       clr_s;
        int         s, c, k;
        logic [3:0] nib;
        @(posedge clk);
        clr_s = clr;
        if (clr_s) begin
            n     = 0;
            m_shd = {8{BLANK}};
            e     = '{an: 8'hFF, seg: 7'h7F, fd: 1'b0};
        end else begin
            n++;
            s   = n - 1;
            c   = s % SD;
            k   = (s / SD) % 8;
            nib = m_shd[4*k +: 4];
            e.an  = (c < DD) ? 8'hFF : ~(8'd1 << k);
            e.seg = (nib == BLANK) ? 7'h7F : dec[nib];
            e.fd  = (n % (8*SD) == 0);
            if (e.fd) m_shd = dataBus;
        end
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        check("AN",         32'(AN),         32'(e.an));
        check("SEG",        32'(SEG),        32'(e.seg));
        check("DP",         32'(DP),         32'(1'b1));
        check("frame_done", 32'(frame_done), 32'(e.fd));
        check("SEG_dead0",  32'(seg0),       32'(e.seg));
        check("FD_dead0",   32'(fd0),        32'(e.fd));
        check("DP_dead0",   32'(dp0),        32'(1'b1));
        if (!clr_s) check("AN_dead0_onehot", $countones(~an0), 1);
        if (frame_done) pulses++;
    endtask

    task automatic hand(string name, logic [7:0] an, logic [6:0] seg, logic fd);
        check({name, "_AN"},  32'(AN),         32'(an));
        check({name, "_SEG"}, 32'(SEG),        32'(seg));
        check({name, "_FD"},  32'(frame_done), 32'(fd));
    endtask

    initial begin
        tbl[0]  = '{1,  32'h01234567, 8'hFF, 7'h7F, 1'b0};
        tbl[1]  = '{2,  32'h01234567, 8'hFE, 7'h7F, 1'b0};
        tbl[2]  = '{8,  32'h01234567, 8'hFD, 7'h7F, 1'b0};
        tbl[3]  = '{32, 32'h01234567, 8'h7F, 7'h7F, 1'b1};
        tbl[4]  = '{33, 32'h01234567, 8'hFF, 7'h78, 1'b0};
        tbl[5]  = '{34, 32'h01234567, 8'hFE, 7'h78, 1'b0};
        tbl[6]  = '{38, 32'h01234567, 8'hFD, 7'h02, 1'b0};
        tbl[7]  = '{49, 32'h01234567, 8'hFF, 7'h30, 1'b0};
        tbl[8]  = '{50, 32'h89ABCDEF, 8'hEF, 7'h30, 1'b0};
        tbl[9]  = '{62, 32'h89ABCDEF, 8'h7F, 7'h40, 1'b0};
        tbl[10] = '{64, 32'h89ABCDEF, 8'h7F, 7'h40, 1'b1};
        tbl[11] = '{66, 32'h89ABCDEF, 8'hFE, 7'h0E, 1'b0};
        tbl[12] = '{78, 32'h89ABCDEF, 8'hF7, 7'h46, 1'b0};
        tbl[13] = '{82, 32'h89ABCDEF, 8'hEF, 7'h7F, 1'b0};
        tbl[14] = '{94, 32'h89ABCDEF, 8'h7F, 7'h00, 1'b0};
        tbl[15] = '{96, 32'h89ABCDEF, 8'h7F, 7'h00, 1'b1};

        // Reset held for a few edges.
        for (int i = 0; i < 3; i++) begin
            step();
            hand("reset", 8'hFF, 7'h7F, 1'b0);
        end
        clr = 1'b0;

        for (int i = 0; i < 16; i++) begin
            dataBus = tbl[i].data;
            while (n < tbl[i].n) step();
            hand($sformatf("vec%0d", i), tbl[i].an, tbl[i].seg, tbl[i].fd);
        end

        pulses = 0;
        while (n < 224) step();
        check("pulse_count", 32'(pulses), 32'd4);

        // Reset in the middle of slot 5.
        while (n < 246) step();
        hand("slot5", 8'hDF, 7'h08, 1'b0);
        clr = 1'b1;
        step();
        hand("midreset", 8'hFF, 7'h7F, 1'b0);
        clr = 1'b0;
        step();
        hand("rel1", 8'hFF, 7'h7F, 1'b0);
        while (n < 6) step();
        hand("rel6", 8'hFD, 7'h7F, 1'b0);
        while (n < 32) step();
        hand("rel32", 8'h7F, 7'h7F, 1'b1);
        step();
        hand("rel33", 8'hFF, 7'h0E, 1'b0);
        step();
        hand("rel34", 8'hFE, 7'h0E, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
